// File: rtl/tdm_frame_receiver.sv
// -----------------------------------------------------------------------------
// tdm_frame_receiver
//
// Receive end of the serial TDM link. It hunts for the sync word with a
// sliding compare, then de-serialises NCH channels of W bits into a parallel
// bank. After each frame it expects another sync word. A mismatch drops lock
// and restarts the hunt.
//
// Frame on the wire: SYNC (MSB first), then channel 0 .. channel NCH-1.
// Each channel is sent MSB first.
//
// Ports:
//   CLK        clock; all state updates on the rising edge
//   RSTN       asynchronous active-low reset
//   DIN        serial data bit
//   DVALID     DIN is accepted only on edges where DVALID=1
//   O          channel bank, O[W*k +: W] = channel k (registered, whole frames only)
//   FRAME_STB  one-cycle pulse on the edge that loads a new frame into O
//   LOCK       high while frame alignment is established
//   SYNC_ERR   one-cycle pulse when an expected sync word mismatches
// -----------------------------------------------------------------------------
module tdm_frame_receiver #(
    parameter int                  W        = 4,
    parameter int                  NCH      = 4,
    parameter int                  SYNC_LEN = 8,
    parameter logic [SYNC_LEN-1:0] SYNC     = 8'hA5
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             DIN,
    input  logic             DVALID,
    output logic [W*NCH-1:0] O,
    output logic             FRAME_STB,
    output logic             LOCK,
    output logic             SYNC_ERR
);

    localparam int P   = W * NCH;
    localparam int PCW = (P > 1) ? $clog2(P) : 1;
    localparam int SCW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
    localparam int FCW = $clog2(SYNC_LEN + 1);

    localparam logic [PCW-1:0] P_LAST    = PCW'(P - 1);
    localparam logic [SCW-1:0] S_LAST    = SCW'(SYNC_LEN - 1);
    localparam logic [FCW-1:0] FILL_FULL = FCW'(SYNC_LEN);
    localparam logic [FCW-1:0] FILL_LAST = FCW'(SYNC_LEN - 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SYNC_LEN-1:0] sr_q, sr_d;
    logic [FCW-1:0]    fill_q, fill_d;
    logic [PCW-1:0]    pcnt_q, pcnt_d;
    logic [SCW-1:0]    scnt_q, scnt_d;
    logic [P-1:0]      pay_q, pay_d;
    logic [P-1:0]      o_q, o_d;
    logic              stb_q, stb_d;
    logic              lock_q, lock_d;
    logic              err_q, err_d;

    logic [SYNC_LEN-1:0] sr_shift;
    logic [P-1:0]        pay_shift;
    logic [P-1:0]        frame_map;

    assign sr_shift  = {sr_q[SYNC_LEN-2:0], DIN};
    assign pay_shift = {pay_q[P-2:0], DIN};

    // Channel 0 arrives first, so after the shift it sits in the top W bits of
    // pay_shift. It must land in O[W-1:0], so the channel order is reversed.
    always_comb begin
        frame_map = '0;
        for (int k = 0; k < NCH; k++) begin
            frame_map[W*k +: W] = pay_shift[P-1-W*k -: W];
        end
    end

    // NOTE: every next-state signal takes its hold value first. Otherwise a
    // path that does not assign it would infer a latch.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        pcnt_d  = pcnt_q;
        scnt_d  = scnt_q;
        pay_d   = pay_q;
        o_d     = o_q;
        lock_d  = lock_q;
        stb_d   = 1'b0;   // pulses clear on the next edge even without DVALID
        err_d   = 1'b0;

        case (state_q)
            HUNT: begin
                if (DVALID) begin
                    sr_d = sr_shift;
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + FCW'(1);
                    end
                    // fill_q counts bits already held in sr, so the current bit
                    // completes a full window when fill_q >= SYNC_LEN-1.
                    if (sr_shift == SYNC && fill_q >= FILL_LAST) begin
                        state_d = PAYLOAD;
                        pcnt_d  = '0;
                    end
                end
            end

            PAYLOAD: begin
                if (DVALID) begin
                    pay_d = pay_shift;
                    if (pcnt_q == P_LAST) begin
                        o_d     = frame_map;
                        stb_d   = 1'b1;
                        lock_d  = 1'b1;
                        state_d = CHECK;
                        scnt_d  = '0;
                    end else begin
                        pcnt_d = pcnt_q + PCW'(1);
                    end
                end
            end

            CHECK: begin
                if (DVALID) begin
                    sr_d = sr_shift;
                    if (scnt_q == S_LAST) begin
                        if (sr_shift == SYNC) begin
                            state_d = PAYLOAD;
                            pcnt_d  = '0;
                        end else begin
                            state_d = HUNT;
                            lock_d  = 1'b0;
                            err_d   = 1'b1;
                            sr_d    = '0;
                            fill_d  = '0;
                        end
                    end else begin
                        scnt_d = scnt_q + SCW'(1);
                    end
                end
            end

            default: begin
                state_d = HUNT;
                lock_d  = 1'b0;
                sr_d    = '0;
                fill_d  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge.
    // NOTE: the payload register is reset along with everything else. This
    // way a reset mid-frame cannot leak stale bits into a later frame.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= HUNT;
            sr_q    <= '0;
            fill_q  <= '0;
            pcnt_q  <= '0;
            scnt_q  <= '0;
            pay_q   <= '0;
            o_q     <= '0;
            stb_q   <= 1'b0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            pcnt_q  <= pcnt_d;
            scnt_q  <= scnt_d;
            pay_q   <= pay_d;
            o_q     <= o_d;
            stb_q   <= stb_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
        end
    end

    assign O         = o_q;
    assign FRAME_STB = stb_q;
    assign LOCK      = lock_q;
    assign SYNC_ERR  = err_q;

endmodule

// File: tb/tb_tdm_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_tdm_frame_receiver
//
// Directed bench for tdm_frame_receiver with the default parameters
// (W=4, NCH=4, SYNC=8'hA5). Inputs change on the falling edge. Outputs are
// sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_tdm_frame_receiver;

    logic        clk;
    logic        rst_n;
    logic        din;
    logic        dvalid;
    logic [15:0] o;
    logic        frame_stb;
    logic        lock;
    logic        sync_err;

    int n_checks;
    int n_pass;

    // Bookkeeping of accepted bits and the bit index at each FRAME_STB pulse.
    int bit_idx;
    int stb_cnt;
    int stb_prev_pos;
    int stb_last_pos;
    int lock_drops;
    bit watch_lock;

    tdm_frame_receiver dut (
        .CLK       (clk),
        .RSTN      (rst_n),
        .DIN       (din),
        .DVALID    (dvalid),
        .O         (o),
        .FRAME_STB (frame_stb),
        .LOCK      (lock),
        .SYNC_ERR  (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        bit_idx      = 0;
        stb_cnt      = 0;
        stb_prev_pos = 0;
        stb_last_pos = 0;
        lock_drops   = 0;
        watch_lock   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        din    = 1'b0;
        dvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        din    = b;
        dvalid = 1'b1;
        @(posedge clk);
        #1;
        bit_idx++;
        if (frame_stb) begin
            stb_cnt++;
            stb_prev_pos = stb_last_pos;
            stb_last_pos = bit_idx;
        end
        if (watch_lock && !lock) lock_drops++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dvalid = 1'b0;
            din    = ~din;   // toggling during gaps must have no effect
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // Payload bit j (0-based, wire order) is bit 3-(j%4) of channel j/4.
    task automatic send_payload_bits(input logic [15:0] v, input int from, input int to);
        for (int j = from; j < to; j++) send_bit(v[4*(j/4) + 3 - (j%4)]);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        din      = 1'b0;
        dvalid   = 1'b0;
        clear_stats();
        #12;

        // ---- reset state ----
        check("rst_o",    {16'h0, o}, 32'h0);
        check("rst_lock", {31'h0, lock}, 32'h0);
        check("rst_stb",  {31'h0, frame_stb}, 32'h0);
        check("rst_err",  {31'h0, sync_err}, 32'h0);

        // ---- clean frame ----
        do_reset();
        send_byte(8'hA5);
        send_payload_bits(16'hA5C3, 0, 15);
        check("clean_no_early_stb", stb_cnt, 0);
        check("clean_o_before",     {16'h0, o}, 32'h0);
        check("clean_lock_before",  {31'h0, lock}, 32'h0);
        send_payload_bits(16'hA5C3, 15, 16);
        check("clean_stb",     {31'h0, frame_stb}, 32'h1);
        check("clean_stb_pos", stb_last_pos, 24);
        check("clean_o",       {16'h0, o}, 32'hA5C3);
        check("clean_lock",    {31'h0, lock}, 32'h1);
        check("clean_err",     {31'h0, sync_err}, 32'h0);
        idle(1);
        check("clean_stb_clear", {31'h0, frame_stb}, 32'h0);

        // ---- bad sync after a locked frame ----
        send_byte(8'h5A);
        check("bad_err",      {31'h0, sync_err}, 32'h1);
        check("bad_lock",     {31'h0, lock}, 32'h0);
        check("bad_o_hold",   {16'h0, o}, 32'hA5C3);
        idle(1);
        check("bad_err_clear", {31'h0, sync_err}, 32'h0);
        send_byte(8'hA5);
        send_payload_bits(16'h0F0F, 0, 16);
        check("relock_stb",  {31'h0, frame_stb}, 32'h1);
        check("relock_lock", {31'h0, lock}, 32'h1);
        check("relock_o",    {16'h0, o}, 32'h0F0F);

        // ---- junk prefix ----
        do_reset();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_byte(8'hA5);
        send_payload_bits(16'h1234, 0, 15);
        check("junk_no_early_lock", {31'h0, lock}, 32'h0);
        check("junk_no_early_stb",  stb_cnt, 0);
        send_payload_bits(16'h1234, 15, 16);
        check("junk_o",       {16'h0, o}, 32'h1234);
        check("junk_stb_pos", stb_last_pos, 27);
        check("junk_lock",    {31'h0, lock}, 32'h1);

        // ---- back-to-back frames ----
        do_reset();
        send_byte(8'hA5);
        send_payload_bits(16'h1111, 0, 16);
        check("b2b_o1", {16'h0, o}, 32'h1111);
        watch_lock = 1'b1;
        send_byte(8'hA5);
        send_payload_bits(16'hFFFF, 0, 16);
        watch_lock = 1'b0;
        check("b2b_stb_cnt",   stb_cnt, 2);
        check("b2b_stb_gap",   stb_last_pos - stb_prev_pos, 24);
        check("b2b_lock_held", lock_drops, 0);
        check("b2b_o2",        {16'h0, o}, 32'hFFFF);

        // ---- DVALID gaps ----
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            send_bit(8'hA5 >> i);
            idle(3);
        end
        for (int j = 0; j < 15; j++) begin
            send_payload_bits(16'hA5C3, j, j + 1);
            idle(3);
        end
        check("gap_no_early_stb", stb_cnt, 0);
        send_payload_bits(16'hA5C3, 15, 16);
        check("gap_stb",     {31'h0, frame_stb}, 32'h1);
        check("gap_stb_pos", stb_last_pos, 24);
        check("gap_o",       {16'h0, o}, 32'hA5C3);
        idle(3);
        check("gap_stb_clear", {31'h0, frame_stb}, 32'h0);
        check("gap_o_hold",    {16'h0, o}, 32'hA5C3);

        // ---- reset mid-operation ----
        do_reset();
        send_byte(8'hA5);
        send_payload_bits(16'hA5C3, 0, 16);
        send_byte(8'hA5);
        send_payload_bits(16'h1234, 0, 12);
        check("mid_lock_before", {31'h0, lock}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_async_o",    {16'h0, o}, 32'h0);
        check("mid_async_lock", {31'h0, lock}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        send_payload_bits(16'h1234, 12, 16);
        check("mid_no_stb_tail", stb_cnt, 0);
        check("mid_lock_tail",   {31'h0, lock}, 32'h0);
        send_byte(8'hA5);
        send_payload_bits(16'h0F0F, 0, 16);
        check("mid_stb_cnt", stb_cnt, 1);
        check("mid_o",       {16'h0, o}, 32'h0F0F);
        check("mid_lock",    {31'h0, lock}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case a wait never completes.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
